clk_divider_bank: RTL and testbench
===================================

// Module: clk_divider_bank
// PURPOSE
//   Bank of NUM_CH independent programmable clock dividers / tick generators off CLK.
//   Per channel: 50%-duty square wave (toggle mode) or 1-cycle strobe (pulse mode).
//   Divisor writes are shadowed and take effect only at a period boundary (glitch-free).
//   Drives display-scan, debounce-sample and LED-blink timing across the lab designs.
// PARAMETERS
//   NUM_CH   4           number of divider channels (1..16)
//   CNT_W    27          divisor / counter width in bits
//   DEF_DIV  50_000_000  divisor loaded into every channel at reset (must fit CNT_W)
// PORTS
//   CLK       in   1               system clock, all logic on rising edge
//   reset     in   1               asynchronous, active-high reset
//   en        in   NUM_CH          per-channel run enable (level)
//   mode      in   NUM_CH          per-channel mode: 0 = toggle, 1 = pulse; latched while en=0
//   load      in   1               1-cycle divisor write strobe
//   load_ch   in   $clog2(NUM_CH)  channel index for the write (min width 1)
//   load_div  in   CNT_W           divisor value for the write
//   out_clk   out  NUM_CH          per-channel divided output (registered)
//   tick      out  NUM_CH          per-channel 1-cycle wrap strobe (registered)
//   pending   out  NUM_CH          1 = shadow divisor written, not yet active
// BEHAVIOUR
//   Reset (async, active-high): cnt=0, out_clk=0, tick=0, pending=0, mode_q=0,
//     active and shadow divisors = DEF_DIV, all channels. Release is synchronous to CLK.
//   Effective divisor D = active divisor, with 0 treated as 1.
//   Counter (per channel, en=1): cnt increments each edge; when cnt >= D-1, cnt <= 0 (wrap).
//     tick <= 1 on the wrap edge, else 0 => tick high exactly 1 cycle every D cycles.
//     First tick after enable occurs D edges after en is first sampled high.
//   Toggle mode (mode_q=0): out_clk inverts on each wrap => period 2*D, 50% duty.
//   Pulse mode (mode_q=1): out_clk equals tick (1 high cycle per D cycles).
//   D=1: tick stuck high; toggle out_clk = CLK/2; pulse out_clk stuck high.
//   Disable (en=0): next edge cnt<=0, tick<=0, out_clk<=0; mode_q <= mode every edge
//     while disabled. mode changes while enabled are ignored.
//   Divisor write: load=1 with load_ch < NUM_CH writes shadow[load_ch] <= load_div.
//     load_ch >= NUM_CH: write ignored, no state change.
//     Channel disabled at the write edge: active <= load_div directly; pending stays 0.
//     Channel enabled, no wrap at that edge: shadow written, pending <= 1.
//     Channel enabled, wrap at that same edge: active <= load_div immediately (new D
//       governs the next period); pending stays 0.
//     On each wrap with pending=1: active <= shadow, pending <= 0.
//     A later write before the boundary overwrites shadow (last write wins).
//   Disable while pending=1: active <= shadow, pending <= 0 at the next edge.
//   Compare is >=: a larger-than-counter mismatch cannot hang a channel; cnt never > D-1
//     except transiently never, since D changes only at wrap or while cnt=0.
//   Channels are fully independent; one shared write port; no combinational in->out paths.
//   reset asserted mid-period: all outputs return to reset values immediately (async).
// TESTING
//   1. NUM_CH=2, CNT_W=8: load ch0 div=4 while en=0, en[0]=1 mode 0 -> out_clk[0] period 8,
//      high 4/low 4; tick[0] high on edges 4, 8, 12.
//   2. ch1 pulse mode, div=3 -> out_clk[1]==tick[1], high 1 cycle every 3; ch0 unaffected.
//   3. ch0 running div=4, write div=6 at cnt=1 -> pending[0]=1 until wrap, then period 12;
//      write coincident with a wrap -> new divisor active with no pending pulse.
//   4. div=0 and div=1 -> both behave as D=1 (toggle CLK/2); load_ch=3 with NUM_CH=2 ignored.
//   5. toggle mid-run: drop en[0] -> out_clk/tick 0 next edge; change mode while en=1 has no
//      effect; re-enable -> first tick exactly D edges later.
//   6. Assert reset mid-period (out_clk=1, pending=1) -> out_clk, tick, pending 0 at once;
//      after release, divisors = DEF_DIV.

Source files
------------

// File: rtl/clk_divider_bank.sv
// Bank of independent programmable clock dividers / tick generators.
// Divisor writes are shadowed and only take effect at a period boundary.
module clk_divider_bank #(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 27,
    parameter  int DEF_DIV = 50_000_000,
    localparam int LCH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt_r, cnt_s;
        logic [CNT_W-1:0] active_r, active_s;
        logic [CNT_W-1:0] shadow_r, shadow_s;
        logic [CNT_W-1:0] div_eff_s;
        logic             pending_r, pending_s;
        logic             mode_r, mode_s;
        logic             out_r, out_s;
        logic             tick_r, tick_s;
        logic             wr_s, wrap_s;

        // Write decode, effective divisor (0 behaves as 1) and wrap detection
        always_comb begin
            wr_s = load && (load_ch == LCH_W'(ch));
            if (active_r == ZERO_C) begin
                div_eff_s = ONE_C;
            end else begin
                div_eff_s = active_r;
            end
            wrap_s = en[ch] && (cnt_r >= (div_eff_s - ONE_C));
        end

        // Next-state for counter, outputs, mode latch and divisor shadowing
        always_comb begin
            cnt_s     = cnt_r;
            tick_s    = tick_r;
            out_s     = out_r;
            mode_s    = mode_r;
            active_s  = active_r;
            shadow_s  = shadow_r;
            pending_s = pending_r;

            if (!en[ch]) begin
                cnt_s  = ZERO_C;
                tick_s = 1'b0;
                out_s  = 1'b0;
                mode_s = mode[ch];
            end else if (wrap_s) begin
                cnt_s  = ZERO_C;
                tick_s = 1'b1;
                out_s  = mode_r ? 1'b1 : ~out_r;
            end else begin
                cnt_s  = cnt_r + ONE_C;
                tick_s = 1'b0;
                out_s  = mode_r ? 1'b0 : out_r;
            end

            // A running channel between boundaries must defer the new divisor
            if (wr_s) begin
                shadow_s = load_div;
                if (en[ch] && !wrap_s) begin
                    pending_s = 1'b1;
                end else begin
                    active_s  = load_div;
                    pending_s = 1'b0;
                end
            end else if (pending_r && (!en[ch] || wrap_s)) begin
                active_s  = shadow_r;
                pending_s = 1'b0;
            end else begin
                active_s  = active_r;
            end
        end

        // Channel state register with asynchronous reset
        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                cnt_r     <= ZERO_C;
                tick_r    <= 1'b0;
                out_r     <= 1'b0;
                mode_r    <= 1'b0;
                active_r  <= DEF_DIV_C;
                shadow_r  <= DEF_DIV_C;
                pending_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_s;
                tick_r    <= tick_s;
                out_r     <= out_s;
                mode_r    <= mode_s;
                active_r  <= active_s;
                shadow_r  <= shadow_s;
                pending_r <= pending_s;
            end
        end

        assign out_clk[ch] = out_r;
        assign tick[ch]    = tick_r;
        assign pending[ch] = pending_r;
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: per-edge scoreboard from a
// behavioural model plus directed timing checks.
module tb_clk_divider_bank;
    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 5;
    localparam int LCH_W   = 2;

    logic              CLK = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en, mode;
    logic              load;
    logic [LCH_W-1:0]  load_ch;
    logic [CNT_W-1:0]  load_div;
    wire  [NUM_CH-1:0] out_clk, tick, pending;

    clk_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .CLK(CLK), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_ch(load_ch), .load_div(load_div),
        .out_clk(out_clk), .tick(tick), .pending(pending)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // behavioural model state
    int m_cnt[NUM_CH], m_act[NUM_CH], m_sh[NUM_CH];
    bit m_pend[NUM_CH], m_mode[NUM_CH], m_out[NUM_CH], m_tick[NUM_CH];

    typedef struct { logic [NUM_CH-1:0] oc, tk, pd; } exp_t;
    exp_t sbq[$];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_act[c] = DEF_DIV; m_sh[c] = DEF_DIV;
            m_pend[c] = 0; m_mode[c] = 0; m_out[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_edge();
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            int d;
            bit wr, wrap;
            d    = (m_act[c] == 0) ? 1 : m_act[c];
            wr   = load && (int'(load_ch) == c);
            wrap = en[c] && (m_cnt[c] >= d - 1);
            if (!en[c]) begin
                m_cnt[c] = 0; m_tick[c] = 0; m_out[c] = 0; m_mode[c] = mode[c];
            end else if (wrap) begin
                m_cnt[c] = 0; m_tick[c] = 1; m_out[c] = m_mode[c] ? 1'b1 : !m_out[c];
            end else begin
                m_cnt[c]++; m_tick[c] = 0;
                if (m_mode[c]) m_out[c] = 0;
            end
            if (wr) begin
                m_sh[c] = int'(load_div);
                if (en[c] && !wrap) m_pend[c] = 1;
                else begin m_act[c] = int'(load_div); m_pend[c] = 0; end
            end else if (m_pend[c] && (!en[c] || wrap)) begin
                m_act[c] = m_sh[c]; m_pend[c] = 0;
            end
            e.oc[c] = m_out[c]; e.tk[c] = m_tick[c]; e.pd[c] = m_pend[c];
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        check_eq("sb_out_clk", int'(out_clk), int'(e.oc));
        check_eq("sb_tick",    int'(tick),    int'(e.tk));
        check_eq("sb_pending", int'(pending), int'(e.pd));
    endtask

    task automatic write_div(input int ch, input int div);
        load = 1'b1; load_ch = LCH_W'(ch); load_div = CNT_W'(div);
        step();
        load = 1'b0;
    endtask

    // edges until tick[ch] rises, bounded; -1 if it never does
    task automatic tick_latency(input int ch, input int exp_n, input string tag);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            n++;
            if (tick[ch]) seen = 1;
        end
        check_eq(tag, seen ? n : -1, exp_n);
    endtask

    initial begin
        reset = 1'b1; en = '0; mode = '0; load = 1'b0; load_ch = '0; load_div = '0;
        model_reset();
        #1;
        check_eq("rst_out_clk", int'(out_clk), 0);
        check_eq("rst_tick",    int'(tick),    0);
        check_eq("rst_pending", int'(pending), 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        step();

        // 1: ch0 toggle, div 4
        write_div(0, 4);
        en[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check_eq("t1_tick", int'(tick[0]), int'(e % 4 == 0));
            check_eq("t1_out",  int'(out_clk[0]), int'((e / 4) % 2 == 1));
        end

        // 2: ch1 pulse, div 3, ch0 keeps running
        mode[1] = 1'b1;
        write_div(1, 3);
        en[1] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            check_eq("t2_tick", int'(tick[1]),    int'(e % 3 == 0));
            check_eq("t2_out",  int'(out_clk[1]), int'(e % 3 == 0));
        end

        // 3: shadowed write at cnt=1, then write coincident with a wrap
        for (int i = 0; i < 20 && m_cnt[0] != 1; i++) step();
        write_div(0, 6);
        check_eq("t3_pending", int'(pending[0]), 1);
        tick_latency(0, 2, "t3_first_wrap");
        check_eq("t3_pend_clr", int'(pending[0]), 0);
        tick_latency(0, 6, "t3_new_period");
        for (int i = 0; i < 20 && m_cnt[0] != 5; i++) step();
        write_div(0, 2);
        check_eq("t3_coinc_tick", int'(tick[0]), 1);
        check_eq("t3_coinc_pend", int'(pending[0]), 0);
        tick_latency(0, 2, "t3_coinc_period");

        // 4: div 0 and div 1 both act as D=1; out-of-range channel ignored
        for (int v = 0; v < 2; v++) begin
            en[0] = 1'b0;
            write_div(0, v);
            en[0] = 1'b1;
            for (int e = 1; e <= 6; e++) begin
                step();
                check_eq("t4_tick", int'(tick[0]),    1);
                check_eq("t4_out",  int'(out_clk[0]), e % 2);
            end
        end
        write_div(3, 7);
        check_eq("t4_badch_pend", int'(pending), 0);

        // 5: disable mid-run, mode change while enabled ignored, re-enable latency
        en[0] = 1'b0;
        write_div(0, 4);
        en[0] = 1'b1;
        tick_latency(0, 4, "t5_first");
        step(); step();
        en[0] = 1'b0;
        step();
        check_eq("t5_dis_out",  int'(out_clk[0]), 0);
        check_eq("t5_dis_tick", int'(tick[0]),    0);
        step();
        en[0] = 1'b1; mode[0] = 1'b1;
        tick_latency(0, 4, "t5_reenable");
        check_eq("t5_out_hi", int'(out_clk[0]), 1);
        step();
        check_eq("t5_toggle_kept", int'(out_clk[0]), 1);
        mode[0] = 1'b0;

        // 6: async reset with out_clk=1 and pending=1
        step();
        write_div(0, 9);
        check_eq("t6_pre_out",  int'(out_clk[0]), 1);
        check_eq("t6_pre_pend", int'(pending[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_out",  int'(out_clk), 0);
        check_eq("t6_rst_tick", int'(tick),    0);
        check_eq("t6_rst_pend", int'(pending), 0);
        model_reset();
        en = '0; mode = '0;
        @(posedge CLK); #1;
        reset = 1'b0;
        en[0] = 1'b1; en[2] = 1'b1;
        tick_latency(0, DEF_DIV, "t6_def_div_ch0");
        check_eq("t6_def_div_ch2", int'(tick[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
